// File: rtl/key_step_conditioner.sv
// Pushbutton front end: synchronises and debounces key_n/mode_in, then emits a
// one-cycle step (with auto-repeat while held) and the mode captured with it.
module key_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = 25
) (
    input  logic       Clock,
    input  logic       resetn,
    input  logic       key_n,
    input  logic [1:0] mode_in,
    output logic       step,
    output logic [1:0] mode,
    output logic       pressed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             key_meta_r;
    logic             key_sync_r;
    logic [1:0]       mode_meta_r;
    logic [1:0]       mode_sync_r;
    logic             key_s;
    logic [1:0]       mode_s;

    logic [CNT_W-1:0] dcnt_r;
    logic             pressed_r;
    logic             differ_s;
    logic             dbnc_done_s;
    logic             rise_s;
    logic             fall_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hcnt_nxt_s;
    logic             step_r;
    logic             step_nxt_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_nxt_s;

    // Two-flop synchronisers; key resets to released so a held key re-presses.
    always_ff @(posedge Clock) begin
        if (resetn) begin
            key_meta_r  <= 1'b1;
            key_sync_r  <= 1'b1;
            mode_meta_r <= 2'b00;
            mode_sync_r <= 2'b00;
        end else begin
            key_meta_r  <= key_n;
            key_sync_r  <= key_meta_r;
            mode_meta_r <= mode_in;
            mode_sync_r <= mode_meta_r;
        end
    end

    assign key_s       = key_sync_r;
    assign mode_s      = mode_sync_r;
    assign differ_s    = (~key_s) != pressed_r;
    assign dbnc_done_s = differ_s && (dcnt_r == DB_LAST);
    assign rise_s      = dbnc_done_s && !pressed_r;
    assign fall_s      = dbnc_done_s && pressed_r;

    // Debounce counter: any agreement between key and accepted level restarts it.
    always_ff @(posedge Clock) begin
        if (resetn) begin
            dcnt_r    <= CNT_ZERO;
            pressed_r <= 1'b0;
        end else if (!differ_s) begin
            dcnt_r    <= CNT_ZERO;
        end else if (dbnc_done_s) begin
            dcnt_r    <= CNT_ZERO;
            pressed_r <= ~pressed_r;
        end else begin
            dcnt_r    <= dcnt_r + CNT_ONE;
        end
    end

    // Step FSM next-state: release wins over a repeat falling due on the same edge.
    always_comb begin
        state_nxt_s = state_r;
        hcnt_nxt_s  = hcnt_r;
        step_nxt_s  = 1'b0;
        mode_nxt_s  = mode_r;
        case (state_r)
            IDLE: begin
                hcnt_nxt_s = CNT_ZERO;
                if (rise_s) begin
                    state_nxt_s = HELD;
                    step_nxt_s  = 1'b1;
                    mode_nxt_s  = mode_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HELD: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                    hcnt_nxt_s  = CNT_ZERO;
                end else if (hcnt_r == DLY_LAST) begin
                    if (REPEAT_EN) begin
                        state_nxt_s = REPEAT;
                        step_nxt_s  = 1'b1;
                        mode_nxt_s  = mode_s;
                        hcnt_nxt_s  = CNT_ZERO;
                    end else begin
                        hcnt_nxt_s  = hcnt_r;
                    end
                end else begin
                    hcnt_nxt_s = hcnt_r + CNT_ONE;
                end
            end
            REPEAT: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                    hcnt_nxt_s  = CNT_ZERO;
                end else if (hcnt_r == PER_LAST) begin
                    step_nxt_s  = 1'b1;
                    mode_nxt_s  = mode_s;
                    hcnt_nxt_s  = CNT_ZERO;
                end else begin
                    hcnt_nxt_s = hcnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                hcnt_nxt_s  = CNT_ZERO;
            end
        endcase
    end

    // FSM state, hold counter and registered outputs.
    always_ff @(posedge Clock) begin
        if (resetn) begin
            state_r <= IDLE;
            hcnt_r  <= CNT_ZERO;
            step_r  <= 1'b0;
            mode_r  <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            hcnt_r  <= hcnt_nxt_s;
            step_r  <= step_nxt_s;
            mode_r  <= mode_nxt_s;
        end
    end

    assign step    = step_r;
    assign mode    = mode_r;
    assign pressed = pressed_r;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Scoreboard bench for key_step_conditioner: stimulus queues expected step
// cycles/modes, a negedge monitor pops and compares each observed step.
module tb_key_step_conditioner;

    logic       Clock;
    logic       resetn;
    logic       key_n;
    logic [1:0] mode_in;
    logic       step;
    logic [1:0] mode;
    logic       pressed;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int         cyc;
        logic [1:0] md;
    } exp_t;

    exp_t exp_q[$];

    key_step_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1'b1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .CNT_W          (25)
    ) dut (
        .Clock  (Clock),
        .resetn (resetn),
        .key_n  (key_n),
        .mode_in(mode_in),
        .step   (step),
        .mode   (mode),
        .pressed(pressed)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic expect_step(input int c, input logic [1:0] m);
        exp_t e;
        e.cyc = c;
        e.md  = m;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed step must match the head of the expected queue.
    always @(negedge Clock) begin
        if (step === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_step at cycle %0d: got step=1 expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_cycle", cyc, e.cyc);
                chk("step_mode", int'(mode), int'(e.md));
            end
        end
    end

    initial begin
        int t;
        int t2;
        resetn  = 1'b1;
        key_n   = 1'b0;
        mode_in = 2'b11;

        // Reset held with key down and mode 11: outputs stay cleared
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_step", int'(step), 0);
            chk("rst_mode", int'(mode), 0);
            chk("rst_pressed", int'(pressed), 0);
        end

        // Press from reset release, mode 01: step six edges later
        resetn  = 1'b0;
        key_n   = 1'b0;
        mode_in = 2'b01;
        expect_step(cyc + 6, 2'b01);
        tick(5);
        chk("press_pressed_early", int'(pressed), 0);
        tick(1);
        chk("press_pressed", int'(pressed), 1);
        tick(1);
        key_n = 1'b1;
        tick(5);
        chk("release_pressed_early", int'(pressed), 1);
        tick(1);
        chk("release_pressed", int'(pressed), 0);
        tick(4);

        // Bounce every 2 cycles: never accepted
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            tick(2);
            key_n = 1'b1;
            tick(2);
        end
        chk("bounce_pressed", int'(pressed), 0);

        // Final fall then hold with auto-repeat and a mid-hold mode change
        key_n = 1'b0;
        t = cyc + 6;
        expect_step(t, 2'b01);
        expect_step(t + 20, 2'b11);
        expect_step(t + 28, 2'b11);
        expect_step(t + 36, 2'b11);
        expect_step(t + 44, 2'b11);
        expect_step(t + 52, 2'b11);
        tick(16);
        mode_in = 2'b11;
        tick(5);
        chk("mode_hold_t15", int'(mode), 1);
        tick(4);
        chk("mode_hold_t19", int'(mode), 1);
        tick(1);
        chk("mode_new_t20", int'(mode), 3);
        tick(34);
        key_n = 1'b1;
        tick(5);
        chk("repeat_release_early", int'(pressed), 1);
        tick(1);
        chk("repeat_release", int'(pressed), 0);
        tick(20);

        // Reset in REPEAT while held: outputs drop, then one fresh press step
        mode_in = 2'b10;
        key_n   = 1'b0;
        t2 = cyc + 6;
        expect_step(t2, 2'b10);
        expect_step(t2 + 20, 2'b10);
        tick(30);
        resetn = 1'b1;
        tick(1);
        chk("midrst_step", int'(step), 0);
        chk("midrst_pressed", int'(pressed), 0);
        chk("midrst_mode", int'(mode), 0);
        tick(1);
        resetn = 1'b0;
        expect_step(cyc + 6, 2'b10);
        tick(6);
        chk("repress_pressed", int'(pressed), 1);
        tick(1);
        key_n = 1'b1;
        tick(30);
        chk("repress_released", int'(pressed), 0);

        chk("pending_steps", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
